// File: rtl/dem_switching_block.sv
// dem_switching_block: DEM tree node splitting x into (x+s)/2 and (x-s)/2, s in {-1,0,+1}
// Optional first-order mismatch shaping enabled by defining SWB_SHAPING_EN.
module dem_switching_block #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] x_in_i,
  input  logic             pn_seq_i,
  output logic [WIDTH-1:0] x_out1_o,
  output logic [WIDTH-1:0] x_out2_o,
  output logic [WIDTH-1:0] s_out_o
);
  logic             odd;
  logic             pos;
  logic [WIDTH:0]   xe;
  logic [WIDTH:0]   up;
  logic [WIDTH:0]   dn;
  logic [WIDTH-1:0] x_out1_q, x_out2_q, s_out_q;
  logic [WIDTH-1:0] x_out1_d, x_out2_d, s_out_d;
  assign odd = x_in_i[0];
  assign xe  = {1'b0, x_in_i};
  assign up  = xe + {{WIDTH{1'b0}}, 1'b1};
  assign dn  = xe - {{WIDTH{1'b0}}, 1'b1};
`ifdef SWB_SHAPING_EN
  typedef enum logic [1:0] {NONE = 2'd0, POS = 2'd1, NEG = 2'd2} sign_t;
  sign_t state_q, state_d;
  // Once a sign is stored, odd codes take the opposite sign so nonzero s alternates.
  always_comb begin
    pos     = (state_q == NONE) ? pn_seq_i : (state_q == NEG);
    state_d = state_q;
    if (odd) state_d = pos ? POS : NEG;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= NONE;
    else         state_q <= state_d;
  end
`else
  assign pos = pn_seq_i;
`endif
  // x+s and x-s are even, so dropping bit 0 is an exact halving.
  always_comb begin
    x_out1_d = !odd ? xe[WIDTH:1] : pos ? up[WIDTH:1] : dn[WIDTH:1];
    x_out2_d = !odd ? xe[WIDTH:1] : pos ? dn[WIDTH:1] : up[WIDTH:1];
    s_out_d  = !odd ? '0 : pos ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_out1_q <= '0;
      x_out2_q <= '0;
      s_out_q  <= '0;
    end else begin
      x_out1_q <= x_out1_d;
      x_out2_q <= x_out2_d;
      s_out_q  <= s_out_d;
    end
  end
  assign x_out1_o = x_out1_q;
  assign x_out2_o = x_out2_q;
  assign s_out_o  = s_out_q;
endmodule

// File: tb/tb_dem_switching_block.sv
// tb_dem_switching_block: table-driven check of the DEM switching node (WIDTH=5)
module tb_dem_switching_block;
  logic       clk = 1'b0;
  logic       reset_i;
  logic [4:0] x_in_i;
  logic       pn_seq_i;
  logic [4:0] x_out1_o, x_out2_o, s_out_o;
  int         n_vec = 0;
  int         n_err = 0;
  typedef struct {
    logic       rst;
    logic [4:0] x;
    logic       pn;
    logic [4:0] e1;
    logic [4:0] e2;
    logic [4:0] es;
  } vec_t;
  vec_t tbl[$];
  dem_switching_block #(.WIDTH(5)) dut (
    .clk_i(clk), .reset_i(reset_i), .x_in_i(x_in_i), .pn_seq_i(pn_seq_i),
    .x_out1_o(x_out1_o), .x_out2_o(x_out2_o), .s_out_o(s_out_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    logic [5:0] sum;
    logic [4:0] dif;
    reset_i  = v.rst;
    x_in_i   = v.x;
    pn_seq_i = v.pn;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d x_out1", idx), {1'b0, x_out1_o}, {1'b0, v.e1});
    chk($sformatf("v%0d x_out2", idx), {1'b0, x_out2_o}, {1'b0, v.e2});
    chk($sformatf("v%0d s_out", idx), {1'b0, s_out_o}, {1'b0, v.es});
    if (!v.rst) begin
      sum = {1'b0, x_out1_o} + {1'b0, x_out2_o};
      dif = x_out1_o - x_out2_o;
      chk($sformatf("v%0d sum_inv", idx), sum, {1'b0, v.x});
      chk($sformatf("v%0d diff_inv", idx), {1'b0, dif}, {1'b0, s_out_o});
      chk($sformatf("v%0d diff_mag", idx), {5'd0, (dif == 5'd0 || dif == 5'd1 || dif == 5'd31)}, 6'd1);
    end
  endtask
  initial begin
    reset_i = 1'b1; x_in_i = '0; pn_seq_i = 1'b0;
`ifdef SWB_SHAPING_EN
    tbl.push_back('{1'b1, 5'd3,  1'b1, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd3,  1'b1, 5'd2,  5'd1,  5'd1});
    tbl.push_back('{1'b0, 5'd3,  1'b1, 5'd1,  5'd2,  5'd31});
    tbl.push_back('{1'b0, 5'd4,  1'b1, 5'd2,  5'd2,  5'd0});
    tbl.push_back('{1'b0, 5'd3,  1'b1, 5'd2,  5'd1,  5'd1});
    tbl.push_back('{1'b1, 5'd3,  1'b1, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd3,  1'b0, 5'd1,  5'd2,  5'd31});
    tbl.push_back('{1'b0, 5'd5,  1'b0, 5'd3,  5'd2,  5'd1});
    tbl.push_back('{1'b0, 5'd31, 1'b1, 5'd15, 5'd16, 5'd31});
`else
    tbl.push_back('{1'b1, 5'd3,  1'b1, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd3,  1'b1, 5'd2,  5'd1,  5'd1});
    tbl.push_back('{1'b0, 5'd5,  1'b0, 5'd2,  5'd3,  5'd31});
    tbl.push_back('{1'b0, 5'd9,  1'b0, 5'd4,  5'd5,  5'd31});
    tbl.push_back('{1'b0, 5'd4,  1'b1, 5'd2,  5'd2,  5'd0});
    tbl.push_back('{1'b0, 5'd12, 1'b0, 5'd6,  5'd6,  5'd0});
    tbl.push_back('{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd31, 1'b1, 5'd16, 5'd15, 5'd1});
    tbl.push_back('{1'b0, 5'd31, 1'b0, 5'd15, 5'd16, 5'd31});
    tbl.push_back('{1'b0, 5'd1,  1'b0, 5'd0,  5'd1,  5'd31});
    tbl.push_back('{1'b0, 5'd1,  1'b1, 5'd1,  5'd0,  5'd1});
    tbl.push_back('{1'b0, 5'd30, 1'b1, 5'd15, 5'd15, 5'd0});
    tbl.push_back('{1'b1, 5'd7,  1'b1, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd7,  1'b1, 5'd4,  5'd3,  5'd1});
    tbl.push_back('{1'b1, 5'd31, 1'b0, 5'd0,  5'd0,  5'd0});
    tbl.push_back('{1'b0, 5'd10, 1'b0, 5'd5,  5'd5,  5'd0});
`endif
    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i], i);
    // Outputs must hold between edges: change inputs mid-cycle and recheck.
    reset_i = 1'b0; x_in_i = 5'd6; pn_seq_i = 1'b0;
    @(posedge clk);
    #1;
    chk("lat x_out1", {1'b0, x_out1_o}, 6'd3);
    x_in_i = 5'd17; pn_seq_i = 1'b1;
    #2;
    chk("hold x_out1", {1'b0, x_out1_o}, 6'd3);
    chk("hold x_out2", {1'b0, x_out2_o}, 6'd3);
    chk("hold s_out", {1'b0, s_out_o}, 6'd0);
    @(posedge clk);
    #1;
    chk("next sum", {1'b0, x_out1_o} + {1'b0, x_out2_o}, 6'd17);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst x_out1", {1'b0, x_out1_o}, 6'd0);
    chk("rst s_out", {1'b0, s_out_o}, 6'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
